oai33_arc_sequencer: RTL and testbench
======================================

OAI33_ARC_SEQUENCER -- requirements
Module: oai33_arc_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, range 1..15: cycles each input vector is held before ZN is sampled.
REQ-002 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RN  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port START  input  1  begin a sweep; sampled only in IDLE or FINISH.
REQ-005 The block SHALL have port ZN_OBS  input  1  observed OAI33 output under test.
REQ-006 The block SHALL have ports A1, A2, A3, B1, B2, B3  output  1 each  stimulus to the OAI33 under test.
REQ-007 The block SHALL have port BUSY  output  1  high in SETTLE and SAMPLE.
REQ-008 The block SHALL have port DONE  output  1  high in FINISH.
REQ-009 The block SHALL have port PASS  output  1  high in FINISH when ERR_CNT is 0.
REQ-010 The block SHALL have port ERR_CNT  output  7  number of mismatching vectors in the current or last sweep.
REQ-011 The block SHALL have port FAIL_VEC  output  6  first mismatching vector {A1,A2,A3,B1,B2,B3}; valid when ERR_CNT is nonzero.

Function
REQ-012 States SHALL be IDLE, SETTLE, SAMPLE and FINISH, held in a registered state machine.
REQ-013 The 6-bit vector register SHALL drive {A1,A2,A3,B1,B2,B3} MSB-first, registered, with no combinational path from any input.
REQ-014 START=1 in IDLE or FINISH SHALL set vector=0, ERR_CNT=0 and FAIL_VEC=0, load the settle counter with SETTLE_CYC-1, and go to SETTLE.
REQ-015 START in SETTLE or SAMPLE SHALL be ignored.
REQ-016 SETTLE SHALL decrement the settle counter and go to SAMPLE when the counter is 0; the vector SHALL be held constant.
REQ-017 SAMPLE SHALL compare ZN_OBS with expected = NOT((A1|A2|A3)&(B1|B2|B3)), computed from the registered vector.
REQ-018 On a mismatch, ERR_CNT SHALL increment, and if ERR_CNT was 0, FAIL_VEC SHALL capture the vector.
REQ-019 From SAMPLE, vector==63 SHALL go to FINISH; otherwise the vector SHALL increment, the counter SHALL reload SETTLE_CYC-1, and the next state SHALL be SETTLE.
REQ-020 Each vector SHALL take SETTLE_CYC+1 cycles, so DONE rises exactly 64*(SETTLE_CYC+1) cycles after the START-accepting edge.
REQ-021 ERR_CNT SHALL be at most 64 and SHALL never wrap.
REQ-022 FINISH SHALL hold DONE, PASS, ERR_CNT, FAIL_VEC and the last vector (63) until START or reset.
REQ-023 START in FINISH SHALL behave exactly as START in IDLE, with no idle cycle in between.

Reset
REQ-024 RN low SHALL immediately force state=IDLE, all stimulus outputs 0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0 and settle counter=0, including mid-sweep.
REQ-025 After RN deasserts, the block SHALL stay in IDLE until START.
REQ-026 A reset mid-sweep SHALL NOT leave any partial result visible.

Configuration
REQ-027 With OAI33_ARC_SEQUENCER_STOP_ON_FAIL_EN defined, a mismatch in SAMPLE SHALL go directly to FINISH with the failing vector held on the outputs, ERR_CNT=1 and PASS=0.
REQ-028 Without OAI33_ARC_SEQUENCER_STOP_ON_FAIL_EN, the block SHALL always sweep all 64 vectors and ERR_CNT SHALL count every mismatch.

Verification
REQ-029 Correct OAI33 model, SETTLE_CYC=2, one-cycle START pulse -> BUSY for 192 cycles, then DONE=1, PASS=1, ERR_CNT=0, outputs = 6'b111111.
REQ-030 ZN_OBS stuck at 1, full sweep -> ERR_CNT=49, FAIL_VEC=6'b001001, PASS=0.
REQ-031 ZN_OBS stuck at 0, full sweep -> ERR_CNT=15, FAIL_VEC=6'b000000; with STOP_ON_FAIL_EN -> DONE 3 cycles after START, ERR_CNT=1.
REQ-032 START held high for the whole sweep -> single sweep during BUSY; an immediate restart on the FINISH edge clears ERR_CNT and vector to 0.
REQ-033 RN pulsed low at vector 20 during SETTLE -> all outputs 0 asynchronously, IDLE after release, a clean sweep on the next START.
REQ-034 SETTLE_CYC=1 and SETTLE_CYC=15 -> DONE at 128 and 1024 cycles respectively, and ZN_OBS is sampled only in the last cycle of each vector.

Source files
------------

// File: rtl/oai33_arc_sequencer.sv
// Built-in self-test sequencer: sweeps all 64 input vectors of an OAI33 cell and counts mismatches.
// Optional macro OAI33_ARC_SEQUENCER_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module oai33_arc_sequencer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rn,
    input  logic       start,
    input  logic       zn_obs,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       b1,
    output logic       b2,
    output logic       b3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_cnt,
    output logic [5:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [6:0] ERR_MAX   = 7'd64;

    // Reference OAI33 response for a packed {A1,A2,A3,B1,B2,B3} vector.
    function automatic logic oai33_expect(input logic [5:0] vec);
        return ~((vec[5] | vec[4] | vec[3]) & (vec[2] | vec[1] | vec[0]));
    endfunction

    state_t     state_r;
    state_t     state_nx_s;
    logic [5:0] vec_r;
    logic [5:0] vec_nx_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nx_s;
    logic [6:0] err_r;
    logic [6:0] err_nx_s;
    logic [5:0] fail_r;
    logic [5:0] fail_nx_s;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic       mismatch_s;

    assign mismatch_s = (zn_obs != oai33_expect(vec_r));

    // Next-state and datapath decisions for the sweep.
    always_comb begin
        state_nx_s = state_r;
        vec_nx_s   = vec_r;
        cnt_nx_s   = cnt_r;
        err_nx_s   = err_r;
        fail_nx_s  = fail_r;
        case (state_r)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_nx_s = ST_SETTLE;
                    vec_nx_s   = 6'd0;
                    cnt_nx_s   = SETTLE_LD;
                    err_nx_s   = 7'd0;
                    fail_nx_s  = 6'd0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = ST_SAMPLE;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    // Counter cannot exceed 64 in one sweep; saturation is only a guard.
                    if (err_r != ERR_MAX) begin
                        err_nx_s = err_r + 7'd1;
                    end else begin
                        err_nx_s = err_r;
                    end
                    if (err_r == 7'd0) begin
                        fail_nx_s = vec_r;
                    end else begin
                        fail_nx_s = fail_r;
                    end
                end else begin
                    err_nx_s = err_r;
                end
`ifdef OAI33_ARC_SEQUENCER_STOP_ON_FAIL_EN
                if (mismatch_s || (vec_r == 6'd63)) begin
                    state_nx_s = ST_FINISH;
                end else begin
                    state_nx_s = ST_SETTLE;
                    vec_nx_s   = vec_r + 6'd1;
                    cnt_nx_s   = SETTLE_LD;
                end
`else
                if (vec_r == 6'd63) begin
                    state_nx_s = ST_FINISH;
                end else begin
                    state_nx_s = ST_SETTLE;
                    vec_nx_s   = vec_r + 6'd1;
                    cnt_nx_s   = SETTLE_LD;
                end
`endif
            end
            default: begin
                state_nx_s = ST_IDLE;
                vec_nx_s   = 6'd0;
                cnt_nx_s   = 4'd0;
                err_nx_s   = 7'd0;
                fail_nx_s  = 6'd0;
            end
        endcase
    end

    // State, vector, settle counter and result registers.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state_r <= ST_IDLE;
            vec_r   <= 6'd0;
            cnt_r   <= 4'd0;
            err_r   <= 7'd0;
            fail_r  <= 6'd0;
        end else begin
            state_r <= state_nx_s;
            vec_r   <= vec_nx_s;
            cnt_r   <= cnt_nx_s;
            err_r   <= err_nx_s;
            fail_r  <= fail_nx_s;
        end
    end

    // Status flags registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_SETTLE) || (state_nx_s == ST_SAMPLE);
            done_r <= (state_nx_s == ST_FINISH);
            pass_r <= (state_nx_s == ST_FINISH) && (err_nx_s == 7'd0);
        end
    end

    assign a1       = vec_r[5];
    assign a2       = vec_r[4];
    assign a3       = vec_r[3];
    assign b1       = vec_r[2];
    assign b2       = vec_r[1];
    assign b3       = vec_r[0];
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_r;
    assign fail_vec = fail_r;

endmodule

// File: tb/tb_oai33_arc_sequencer.sv
// Self-checking bench for oai33_arc_sequencer: table rows, randomized sweeps and timing corners.
module tb_oai33_arc_sequencer;

    logic       clk;
    logic       rn;
    logic       start, zn_obs;
    logic       a1, a2, a3, b1, b2, b3, busy, done, pass;
    logic [6:0] err_cnt;
    logic [5:0] fail_vec;

    logic       start_1;
    logic       a1_1, a2_1, a3_1, b1_1, b2_1, b3_1, busy_1, done_1, pass_1, zn_1;
    logic [6:0] err_1;
    logic [5:0] fv_1;

    logic       start_15;
    logic       a1_15, a2_15, a3_15, b1_15, b2_15, b3_15, busy_15, done_15, pass_15, zn_15;
    logic [6:0] err_15;
    logic [5:0] fv_15;

    int n_cmp = 0;
    int n_bad = 0;

    oai33_arc_sequencer #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rn(rn), .start(start), .zn_obs(zn_obs),
        .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    oai33_arc_sequencer #(.SETTLE_CYC(1)) dut_s1 (
        .clk(clk), .rn(rn), .start(start_1), .zn_obs(zn_1),
        .a1(a1_1), .a2(a2_1), .a3(a3_1), .b1(b1_1), .b2(b2_1), .b3(b3_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .err_cnt(err_1), .fail_vec(fv_1)
    );

    oai33_arc_sequencer #(.SETTLE_CYC(15)) dut_s15 (
        .clk(clk), .rn(rn), .start(start_15), .zn_obs(zn_15),
        .a1(a1_15), .a2(a2_15), .a3(a3_15), .b1(b1_15), .b2(b2_15), .b3(b3_15),
        .busy(busy_15), .done(done_15), .pass(pass_15), .err_cnt(err_15), .fail_vec(fv_15)
    );

    // Fault-free cells attached to the slow and fast instances.
    assign zn_1  = ~((a1_1 | a2_1 | a3_1) & (b1_1 | b2_1 | b3_1));
    assign zn_15 = ~((a1_15 | a2_15 | a3_15) & (b1_15 | b2_15 | b3_15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] dut_vec();
        return {a1, a2, a3, b1, b2, b3};
    endfunction

    // OAI33 truth from the vector number: low only when both the A and B groups have a 1.
    function automatic bit ref_zn(input int v);
        int a_grp = v / 8;
        int b_grp = v % 8;
        return !((a_grp != 0) && (b_grp != 0));
    endfunction

    function automatic logic [63:0] good_pattern();
        logic [63:0] p;
        for (int v = 0; v < 64; v++) p[v] = ref_zn(v);
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected sweep outcome for a given per-vector observed response.
    task automatic model(input logic [63:0] obs, output int err, output int fail,
                         output int last, output int dcyc);
        bit stopped = 1'b0;
        err  = 0;
        fail = 0;
        last = 63;
        for (int v = 0; v < 64; v++) begin
            if (!stopped && (obs[v] != ref_zn(v))) begin
                if (err == 0) fail = v;
                err++;
`ifdef OAI33_ARC_SEQUENCER_STOP_ON_FAIL_EN
                stopped = 1'b1;
                last    = v;
`endif
            end
        end
        dcyc = (last + 1) * 3;
    endtask

    // One sweep on the SETTLE_CYC=2 instance; obs[v] is presented only in the sample cycle of v.
    task automatic run_sweep(input string name, input logic [63:0] obs, input int exp_err,
                             input int exp_fail, input bit exp_pass, input int exp_done,
                             input int exp_last, input bit hold);
        bit vec_ok = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        zn_obs = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int tc = 0; tc <= exp_done + 2; tc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if ((tc < exp_done) && (tc % 3 == 2)) zn_obs = obs[tc / 3];
            else zn_obs = 1'($urandom_range(0, 1));
            if ((tc < exp_done) && (dut_vec() != 6'(tc / 3))) vec_ok = 1'b0;
            if (tc == exp_done - 1) begin
                chk({name, ".busy_pre"}, 64'(busy), 64'd1);
                chk({name, ".done_pre"}, 64'(done), 64'd0);
            end
            if (tc == exp_done) begin
                chk({name, ".done"}, 64'(done), 64'd1);
                chk({name, ".busy_end"}, 64'(busy), 64'd0);
                chk({name, ".pass"}, 64'(pass), 64'(exp_pass));
                chk({name, ".err_cnt"}, 64'(err_cnt), 64'(exp_err));
                chk({name, ".fail_vec"}, 64'(fail_vec), 64'(exp_fail));
                chk({name, ".last_vec"}, 64'(dut_vec()), 64'(exp_last));
            end
            if ((tc == exp_done + 2) && !hold) begin
                chk({name, ".hold_done"}, 64'(done), 64'd1);
                chk({name, ".hold_err"}, 64'(err_cnt), 64'(exp_err));
                chk({name, ".hold_vec"}, 64'(dut_vec()), 64'(exp_last));
            end
            if ((tc == exp_done + 1) && hold) begin
                chk({name, ".restart_busy"}, 64'(busy), 64'd1);
                chk({name, ".restart_err"}, 64'(err_cnt), 64'd0);
                chk({name, ".restart_vec"}, 64'(dut_vec()), 64'd0);
            end
        end
        chk({name, ".vec_track"}, 64'(vec_ok), 64'd1);
        start = 1'b0;
    endtask

    typedef struct {
        int mode;
        int exp_err;
        int exp_fail;
        bit exp_pass;
        int exp_done;
        int exp_last;
    } vec_t;

    vec_t        tbl[4];
    logic [63:0] obs;
    int          m_err, m_fail, m_last, m_done;
    int          d1, d15;

    initial begin
        // mode: 0 good cell, 1 stuck at 1, 2 stuck at 0, 3 single bad response at vector 37
`ifdef OAI33_ARC_SEQUENCER_STOP_ON_FAIL_EN
        tbl[0] = '{0, 0,  0,  1'b1, 192, 63};
        tbl[1] = '{1, 1,  9,  1'b0, 30,  9};
        tbl[2] = '{2, 1,  0,  1'b0, 3,   0};
        tbl[3] = '{3, 1,  37, 1'b0, 114, 37};
`else
        tbl[0] = '{0, 0,  0,  1'b1, 192, 63};
        tbl[1] = '{1, 49, 9,  1'b0, 192, 63};
        tbl[2] = '{2, 15, 0,  1'b0, 192, 63};
        tbl[3] = '{3, 1,  37, 1'b0, 192, 63};
`endif
        start = 1'b0; start_1 = 1'b0; start_15 = 1'b0; zn_obs = 1'b0;
        rn = 1'b1;
        #1 rn = 1'b0;
        #1;
        chk("reset_outputs", 64'({dut_vec(), busy, done, pass, err_cnt, fail_vec}), 64'd0);
        repeat (3) @(negedge clk);
        rn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", 64'({busy, done, dut_vec()}), 64'd0);

        for (int i = 0; i < 4; i++) begin
            case (tbl[i].mode)
                0:       obs = good_pattern();
                1:       obs = '1;
                2:       obs = '0;
                default: obs = good_pattern() ^ (64'd1 << 37);
            endcase
            run_sweep($sformatf("tbl%0d", i), obs, tbl[i].exp_err, tbl[i].exp_fail,
                      tbl[i].exp_pass, tbl[i].exp_done, tbl[i].exp_last, 1'b0);
        end

        for (int r = 0; r < 5; r++) begin
            obs = good_pattern() ^ ({$urandom(), $urandom()} & {$urandom(), $urandom()}
                                    & {$urandom(), $urandom()});
            model(obs, m_err, m_fail, m_last, m_done);
            run_sweep($sformatf("rand%0d", r), obs, m_err, m_fail, (m_err == 0),
                      m_done, m_last, 1'b0);
        end

        // START held through a sweep, then restart on the FINISH edge
        obs = '1;
        model(obs, m_err, m_fail, m_last, m_done);
        run_sweep("hold_start", obs, m_err, m_fail, 1'b0, m_done, m_last, 1'b1);

        // A fresh sweep began one edge before the hold sweep ended; reach vector 20 in SETTLE.
        repeat (59) @(negedge clk);
        chk("pre_reset_vec", 64'(dut_vec()), 64'd20);
        #2 rn = 1'b0;
        #1;
        chk("midsweep_reset", 64'({dut_vec(), busy, done, pass, err_cnt, fail_vec}), 64'd0);
        @(negedge clk);
        rn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_midreset", 64'({busy, done, dut_vec(), err_cnt}), 64'd0);
        run_sweep("clean_after_reset", good_pattern(), 0, 0, 1'b1, 192, 63, 1'b0);

        // Extreme settle lengths on fault-free cells
        d1 = -1;
        d15 = -1;
        @(negedge clk);
        start_1 = 1'b1;
        start_15 = 1'b1;
        @(posedge clk);
        for (int tc = 0; tc < 1100; tc++) begin
            @(negedge clk);
            start_1 = 1'b0;
            start_15 = 1'b0;
            if (done_1 && (d1 < 0)) d1 = tc;
            if (done_15 && (d15 < 0)) d15 = tc;
        end
        chk("s1_done_cycle", 64'(d1), 64'd128);
        chk("s15_done_cycle", 64'(d15), 64'd1024);
        chk("s1_pass", 64'({pass_1, err_1}), 64'({1'b1, 7'd0}));
        chk("s15_pass", 64'({pass_15, err_15}), 64'({1'b1, 7'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
